// File: rtl/pll_lock_seq_ctrl.sv
// pll_lock_seq_ctrl
// Reset sequencer and lock supervisor for the GTP_PLL_E3 clock wrapper.
// Runs entirely on the PLL reference clock (clkin1). It pulses the PLL reset,
// waits for a synchronized lock, qualifies that lock over a stability window,
// retries on timeout and re-sequences when lock drops while running.
// Optional feature: define PLL_LOSS_CNT_EN to build the saturating loss_cnt
// counter; without it loss_cnt is tied to zero.
module pll_lock_seq_ctrl #(
   parameter int RST_CYCLES    = 8,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int STABLE_CYCLES = 256,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clkin1,
   input  logic       rst_n,
   input  logic       restart,
   input  logic       pll_lock,
   output logic       pll_rst,
   output logic       pll_ready,
   output logic       pll_fail,
   output logic       lock_lost,
   output logic [3:0] retry_cnt,
   output logic [2:0] state_dbg,
   output logic [7:0] loss_cnt
);

   // One shared counter must hold the largest of the three cycle budgets
   localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             sync_s1;
   logic             lock_s;
   logic [3:0]       retry_nxt;
   logic             rst_d;
   logic             ready_d;
   logic             fail_d;
   logic             lost_d;

   // Two-flop synchronizer bringing the asynchronous raw lock into clkin1
   always_ff @(posedge clkin1) begin
      if (!rst_n) begin
         sync_s1 <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         sync_s1 <= pll_lock;
         lock_s  <= sync_s1;
      end
   end

   // State register and the shared phase counter
   always_ff @(posedge clkin1) begin
      if (!rst_n) begin
         state <= S_RESET;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic: restart overrides every state, including a timeout in the same cycle
   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      if (restart) begin
         state_nxt = S_RESET;
         retry_nxt = 4'd0;
      end else begin
         case (state)
            S_RESET: begin
               if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = S_STABLE;
               end else if (cnt == TIMEOUT_LAST) begin
                  retry_nxt = retry_cnt + 4'd1;
                  state_nxt = (retry_nxt >= RETRY_LIMIT) ? S_FAIL : S_RESET;
               end
            end
            S_STABLE: begin
               if (!lock_s) begin
                  state_nxt = S_WAIT_LOCK;
               end else if (cnt == STABLE_LAST) begin
                  state_nxt = S_RUN;
                  retry_nxt = 4'd0;
               end
            end
            S_RUN: begin
               if (!lock_s) state_nxt = S_RESET;
            end
            S_FAIL: begin
               state_nxt = S_FAIL;
            end
            default: begin
               state_nxt = S_RESET;
            end
         endcase
      end
      // The counter restarts on any state change or restart; RUN and FAIL are untimed
      if (restart || (state_nxt != state) || (state == S_RUN) || (state == S_FAIL))
         cnt_nxt = '0;
      else
         cnt_nxt = cnt + CNT_W'(1);
   end

   // Output decode from the upcoming state, so registered outputs line up with the state
   always_comb begin
      rst_d   = (state_nxt == S_RESET) || (state_nxt == S_FAIL);
      ready_d = (state_nxt == S_RUN);
      fail_d  = (state_nxt == S_FAIL);
      lost_d  = (state == S_RUN) && !lock_s;
   end

   // Output registers: no combinational path from any input to any output
   always_ff @(posedge clkin1) begin
      if (!rst_n) begin
         pll_rst   <= 1'b1;
         pll_ready <= 1'b0;
         pll_fail  <= 1'b0;
         lock_lost <= 1'b0;
         retry_cnt <= 4'd0;
      end else begin
         pll_rst   <= rst_d;
         pll_ready <= ready_d;
         pll_fail  <= fail_d;
         lock_lost <= lost_d;
         retry_cnt <= retry_nxt;
      end
   end

   assign state_dbg = state;

`ifdef PLL_LOSS_CNT_EN
   // Saturating count of lock losses; only rst_n clears it, restart keeps it
   always_ff @(posedge clkin1) begin
      if (!rst_n)
         loss_cnt <= 8'd0;
      else if (lost_d && (loss_cnt != 8'hFF))
         loss_cnt <= loss_cnt + 8'd1;
   end
`else
   assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_seq_ctrl.sv
// Testbench for pll_lock_seq_ctrl with RST_CYCLES=8, LOCK_TIMEOUT=64,
// STABLE_CYCLES=16, MAX_RETRY=3. Directed scenarios check timings taken from
// the sequencing rules; a phase/countdown reference model checks every cycle.
// Timing: "t" counts clock edges after the last edge that sampled rst_n=0.
module tb_pll_lock_seq_ctrl;

   localparam int RST_CYCLES    = 8;
   localparam int LOCK_TIMEOUT  = 64;
   localparam int STABLE_CYCLES = 16;
   localparam int MAX_RETRY     = 3;
`ifdef PLL_LOSS_CNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       restart = 1'b0;
   logic       pll_lock = 1'b0;
   logic       pll_rst, pll_ready, pll_fail, lock_lost;
   logic [3:0] retry_cnt;
   logic [2:0] state_dbg;
   logic [7:0] loss_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: phase code (RESET=0..FAIL=4), cycles left in the phase, lock history
   int m_phase = 0;
   int m_left = RST_CYCLES;
   bit m_s1 = 0, m_s2 = 0;
   int m_retry = 0;
   int m_loss = 0;
   bit m_rst = 1, m_ready = 0, m_fail = 0, m_lost = 0;

   wire [18:0] dut_vec = {pll_rst, pll_ready, pll_fail, lock_lost, retry_cnt, state_dbg, loss_cnt};

   pll_lock_seq_ctrl #(
      .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clkin1(clk), .rst_n(rst_n), .restart(restart), .pll_lock(pll_lock),
      .pll_rst(pll_rst), .pll_ready(pll_ready), .pll_fail(pll_fail),
      .lock_lost(lock_lost), .retry_cnt(retry_cnt), .state_dbg(state_dbg),
      .loss_cnt(loss_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] exp_vec();
      return {m_rst, m_ready, m_fail, m_lost, 4'(m_retry), 3'(m_phase), 8'(m_loss)};
   endfunction

   task automatic model_step();
      bit ls;
      if (!rst_n) begin
         m_phase = 0; m_left = RST_CYCLES; m_s1 = 0; m_s2 = 0;
         m_retry = 0; m_loss = 0; m_lost = 0;
      end else begin
         ls = m_s2;
         m_s2 = m_s1;
         m_s1 = pll_lock;
         m_lost = (m_phase == 3) && !ls;
         if (restart) begin
            m_phase = 0; m_left = RST_CYCLES; m_retry = 0;
         end else begin
            case (m_phase)
               0: begin
                  m_left--;
                  if (m_left == 0) begin m_phase = 1; m_left = LOCK_TIMEOUT; end
               end
               1: begin
                  if (ls) begin
                     m_phase = 2; m_left = STABLE_CYCLES;
                  end else begin
                     m_left--;
                     if (m_left == 0) begin
                        m_retry++;
                        if (m_retry >= MAX_RETRY) m_phase = 4;
                        else begin m_phase = 0; m_left = RST_CYCLES; end
                     end
                  end
               end
               2: begin
                  if (!ls) begin
                     m_phase = 1; m_left = LOCK_TIMEOUT;
                  end else begin
                     m_left--;
                     if (m_left == 0) begin m_phase = 3; m_retry = 0; end
                  end
               end
               3: if (!ls) begin m_phase = 0; m_left = RST_CYCLES; end
               default: ;
            endcase
         end
         if (LOSS_EN && m_lost && m_loss < 255) m_loss++;
      end
      m_rst   = (m_phase == 0) || (m_phase == 4);
      m_ready = (m_phase == 3);
      m_fail  = (m_phase == 4);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      restart = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; restart = 1'b1; pll_lock = 1'b1;
      repeat (3) tick();
      vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL reset_pll_rst: got %0b want 1", pll_rst); end
      vectors++; if (pll_ready !== 1'b0) begin miscompares++; $display("FAIL reset_pll_ready: got %0b want 0", pll_ready); end
      vectors++; if (pll_fail !== 1'b0) begin miscompares++; $display("FAIL reset_pll_fail: got %0b want 0", pll_fail); end
      vectors++; if (lock_lost !== 1'b0) begin miscompares++; $display("FAIL reset_lock_lost: got %0b want 0", lock_lost); end
      vectors++; if (retry_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
      vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
      vectors++; if (loss_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_loss: got %0d want 0", loss_cnt); end
      restart = 1'b0; pll_lock = 1'b0;
   endtask

   task automatic test_nominal();
      pll_lock = 1'b0;
      do_reset();
      for (int t = 1; t <= 40; t++) begin
         if (t == 20) pll_lock = 1'b1;
         tick();
         vectors++; if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL nom_model t=%0d: got %h want %h", t, dut_vec, exp_vec()); end
         if (t == 7) begin vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL nom_rst_hi: got %0b want 1", pll_rst); end end
         if (t == 8) begin vectors++; if ({pll_rst, state_dbg} !== {1'b0, 3'd1}) begin miscompares++; $display("FAIL nom_wait: got %h want 1", {pll_rst, state_dbg}); end end
         if (t == 21) begin vectors++; if (state_dbg !== 3'd1) begin miscompares++; $display("FAIL nom_pre_stable: got %0d want 1", state_dbg); end end
         if (t == 22) begin vectors++; if (state_dbg !== 3'd2) begin miscompares++; $display("FAIL nom_stable: got %0d want 2", state_dbg); end end
         if (t == 37) begin vectors++; if (pll_ready !== 1'b0) begin miscompares++; $display("FAIL nom_ready_early: got %0b want 0", pll_ready); end end
         if (t == 38) begin vectors++; if ({pll_ready, retry_cnt, state_dbg} !== {1'b1, 4'd0, 3'd3}) begin miscompares++; $display("FAIL nom_run: got %h want %h", {pll_ready, retry_cnt, state_dbg}, {1'b1, 4'd0, 3'd3}); end end
      end
   endtask

   task automatic test_glitch();
      pll_lock = 1'b0;
      do_reset();
      for (int t = 1; t <= 52; t++) begin
         if (t == 20) pll_lock = 1'b1;
         if (t == 32) pll_lock = 1'b0;
         if (t == 33) pll_lock = 1'b1;
         tick();
         vectors++; if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL glitch_model t=%0d: got %h want %h", t, dut_vec, exp_vec()); end
         if (t == 33) begin vectors++; if (state_dbg !== 3'd2) begin miscompares++; $display("FAIL glitch_pre: got %0d want 2", state_dbg); end end
         if (t == 34) begin vectors++; if ({pll_rst, state_dbg} !== {1'b0, 3'd1}) begin miscompares++; $display("FAIL glitch_back_wait: got %h want 1", {pll_rst, state_dbg}); end end
         if (t == 35) begin vectors++; if (state_dbg !== 3'd2) begin miscompares++; $display("FAIL glitch_restable: got %0d want 2", state_dbg); end end
         if (t == 50) begin vectors++; if (pll_ready !== 1'b0) begin miscompares++; $display("FAIL glitch_ready_early: got %0b want 0", pll_ready); end end
         if (t == 51) begin vectors++; if (pll_ready !== 1'b1) begin miscompares++; $display("FAIL glitch_ready: got %0b want 1", pll_ready); end end
      end
   endtask

   task automatic test_timeout();
      int attempt;
      attempt = RST_CYCLES + LOCK_TIMEOUT;
      pll_lock = 1'b0;
      do_reset();
      for (int t = 1; t <= 230; t++) begin
         tick();
         vectors++; if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL to_model t=%0d: got %h want %h", t, dut_vec, exp_vec()); end
         if (t == attempt) begin vectors++; if ({retry_cnt, state_dbg} !== {4'd1, 3'd0}) begin miscompares++; $display("FAIL to_first: got %h want %h", {retry_cnt, state_dbg}, {4'd1, 3'd0}); end end
         if (t == 2 * attempt) begin vectors++; if (retry_cnt !== 4'd2) begin miscompares++; $display("FAIL to_second: got %0d want 2", retry_cnt); end end
         if (t == 3 * attempt - 1) begin vectors++; if ({pll_fail, state_dbg} !== {1'b0, 3'd1}) begin miscompares++; $display("FAIL to_pre_fail: got %h want 1", {pll_fail, state_dbg}); end end
         if (t == 3 * attempt) begin vectors++; if ({pll_fail, pll_rst, retry_cnt, state_dbg} !== {1'b1, 1'b1, 4'd3, 3'd4}) begin miscompares++; $display("FAIL to_fail: got %h want %h", {pll_fail, pll_rst, retry_cnt, state_dbg}, {1'b1, 1'b1, 4'd3, 3'd4}); end end
      end
      vectors++; if ({pll_fail, pll_rst} !== 2'b11) begin miscompares++; $display("FAIL to_sticky: got %b want 11", {pll_fail, pll_rst}); end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      vectors++; if ({pll_fail, pll_rst, retry_cnt, state_dbg} !== {1'b0, 1'b1, 4'd0, 3'd0}) begin miscompares++; $display("FAIL to_restart: got %h want %h", {pll_fail, pll_rst, retry_cnt, state_dbg}, {1'b0, 1'b1, 4'd0, 3'd0}); end
      repeat (RST_CYCLES - 1) tick();
      vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL to_new_rst: got %0d want 0", state_dbg); end
      tick();
      vectors++; if ({pll_rst, state_dbg} !== {1'b0, 3'd1}) begin miscompares++; $display("FAIL to_new_wait: got %h want 1", {pll_rst, state_dbg}); end
   endtask

   task automatic test_loss_in_run();
      pll_lock = 1'b0;
      do_reset();
      for (int t = 1; t <= 56; t++) begin
         if (t == 20) pll_lock = 1'b1;
         if (t == 45) pll_lock = 1'b0;
         tick();
         vectors++; if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL loss_model t=%0d: got %h want %h", t, dut_vec, exp_vec()); end
         if (t == 46) begin vectors++; if ({lock_lost, pll_ready} !== 2'b01) begin miscompares++; $display("FAIL loss_early: got %b want 01", {lock_lost, pll_ready}); end end
         if (t == 47) begin vectors++; if ({lock_lost, pll_ready, pll_rst} !== 3'b101) begin miscompares++; $display("FAIL loss_pulse: got %b want 101", {lock_lost, pll_ready, pll_rst}); end end
         if (t == 48) begin vectors++; if (lock_lost !== 1'b0) begin miscompares++; $display("FAIL loss_one_cycle: got %0b want 0", lock_lost); end end
         if (t == 54) begin vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL loss_rst_hold: got %0b want 1", pll_rst); end end
         if (t == 55) begin vectors++; if (pll_rst !== 1'b0) begin miscompares++; $display("FAIL loss_rst_end: got %0b want 0", pll_rst); end end
      end
      vectors++; if (loss_cnt !== (LOSS_EN ? 8'd1 : 8'd0)) begin miscompares++; $display("FAIL loss_cnt: got %0d want %0d", loss_cnt, LOSS_EN ? 1 : 0); end
   endtask

   task automatic test_collisions();
      pll_lock = 1'b0;
      do_reset();
      for (int t = 1; t <= 48; t++) begin
         if (t == 20) pll_lock = 1'b1;
         if (t == 45) pll_lock = 1'b0;
         restart = (t == 47);
         tick();
         if (t == 47) begin vectors++; if ({lock_lost, pll_ready, pll_rst, state_dbg} !== {3'b101, 3'd0}) begin miscompares++; $display("FAIL col_loss_restart: got %h want %h", {lock_lost, pll_ready, pll_rst, state_dbg}, {3'b101, 3'd0}); end end
      end
      restart = 1'b0;
      pll_lock = 1'b0;
      do_reset();
      for (int t = 1; t <= 144; t++) begin
         restart = (t == 72);
         tick();
         vectors++; if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL col_model t=%0d: got %h want %h", t, dut_vec, exp_vec()); end
         if (t == 72) begin vectors++; if ({retry_cnt, state_dbg} !== {4'd0, 3'd0}) begin miscompares++; $display("FAIL col_to_restart: got %h want 0", {retry_cnt, state_dbg}); end end
         if (t == 143) begin vectors++; if (retry_cnt !== 4'd0) begin miscompares++; $display("FAIL col_retry_hold: got %0d want 0", retry_cnt); end end
         if (t == 144) begin vectors++; if (retry_cnt !== 4'd1) begin miscompares++; $display("FAIL col_retry_next: got %0d want 1", retry_cnt); end end
      end
      restart = 1'b0;
   endtask

   task automatic test_midop_reset();
      pll_lock = 1'b0;
      do_reset();
      for (int t = 1; t <= 34; t++) begin
         if (t == 20) pll_lock = 1'b1;
         if (t == 26) begin rst_n = 1'b0; restart = 1'b1; end
         if (t == 27) begin rst_n = 1'b1; restart = 1'b0; end
         tick();
         if (t == 25) begin vectors++; if (state_dbg !== 3'd2) begin miscompares++; $display("FAIL mid_pre: got %0d want 2", state_dbg); end end
         if (t == 26) begin vectors++; if (dut_vec !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 8'd0}) begin miscompares++; $display("FAIL mid_reset: got %h want %h", dut_vec, {1'b1, 18'd0}); end end
         if (t == 33) begin vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL mid_rst_len: got %0d want 0", state_dbg); end end
         if (t == 34) begin vectors++; if (state_dbg !== 3'd1) begin miscompares++; $display("FAIL mid_wait: got %0d want 1", state_dbg); end end
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      pll_lock = 1'b0;
      do_reset();
      for (int i = 0; i < 5000; i++) begin
         if (hold == 0) begin
            pll_lock = ~pll_lock;
            hold = pll_lock ? $urandom_range(3, 90) : $urandom_range(1, 120);
         end else begin
            hold--;
         end
         restart = ($urandom_range(0, 149) == 0);
         rst_n = ($urandom_range(0, 399) != 0);
         tick();
         vectors++; if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL rand_model i=%0d: got %h want %h", i, dut_vec, exp_vec()); end
      end
      restart = 1'b0;
      rst_n = 1'b1;
   endtask

`ifdef PLL_LOSS_CNT_EN
   task automatic test_saturation();
      pll_lock = 1'b0;
      do_reset();
      for (int p = 0; p < 300; p++) begin
         for (int c = 0; c < 43; c++) begin
            pll_lock = (c < 40);
            tick();
            vectors++; if (dut_vec !== exp_vec()) begin miscompares++; $display("FAIL sat_model p=%0d: got %h want %h", p, dut_vec, exp_vec()); end
         end
      end
      vectors++; if (loss_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_loss: got %0d want 255", loss_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_nominal();
      test_glitch();
      test_timeout();
      test_loss_in_run();
      test_collisions();
      test_midop_reset();
      test_random();
`ifdef PLL_LOSS_CNT_EN
      test_saturation();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
